crc16_frame_rx: RTL and testbench

//  Receive-side framer/checker for the 4FSK CRC link. Consumes the demodulated

---
 rtl/crc16_frame_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_crc16_frame_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_rx.sv
// rtl/crc16_frame_rx.sv - serial sync-hunting frame receiver with CRC-16/CCITT-FALSE check
//
// crc16_step     : one-bit MSB-first CRC-16 update (non-reflected)
//   crc_i        in  16  current CRC register
//   bit_i        in  1   incoming bit
//   crc_o        out 16  updated CRC register
//
// crc16_frame_rx : hunts for SYNC_WORD, deserialises DATA_W payload bits and a
//                  16-bit CRC, checks the CRC and reports the frame
//   clk_sys      in  1       system clock, rising edge
//   rst_n        in  1       asynchronous reset, active high
//   bit_in       in  1       received bit, sampled when bit_valid=1
//   bit_valid    in  1       symbol strobe
//   data_out     out DATA_W  last completed payload, MSB = first bit received
//   frame_done   out 1       pulse when a frame completes
//   crc_ok       out 1       CRC result of the last completed frame
//   crc_err      out 1       pulse with frame_done on CRC mismatch
//   abort        out 1       pulse on inter-bit timeout
//   sync_lock    out 1       high while receiving payload or CRC
//   err_cnt      out 8       saturating count of CRC-failed frames

module crc16_step #(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic [15:0] crc_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);
    logic fb;

    assign fb    = crc_i[15] ^ bit_i;
    assign crc_o = {crc_i[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
endmodule

module crc16_frame_rx #(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter logic [15:0] POLY      = 16'h1021,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF,
    parameter int          TIMEOUT   = 1024
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic              abort,
    output logic              sync_lock,
    output logic [7:0]        err_cnt
);
    localparam int BCW = 8;
    localparam int IW  = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        sh_q, sh_d;
    logic [4:0]         hunt_cnt_q, hunt_cnt_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]        crc_q, crc_d;
    logic [DATA_W-1:0]  payload_q, payload_d;
    logic [15:0]        rx_crc_q, rx_crc_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               crc_ok_q, crc_ok_d;
    logic               frame_done_q, frame_done_d;
    logic               crc_err_q, crc_err_d;
    logic               abort_q, abort_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [15:0]        sh_shift;
    logic [15:0]        rx_shift;
    logic [4:0]         hunt_inc;
    logic [15:0]        crc_step;
    logic               crc_match;

    crc16_step #(.POLY(POLY)) u_crc_step (
        .crc_i (crc_q),
        .bit_i (bit_in),
        .crc_o (crc_step)
    );

    assign sh_shift  = {sh_q[14:0], bit_in};
    assign rx_shift  = {rx_crc_q[14:0], bit_in};
    assign hunt_inc  = (hunt_cnt_q == 5'd16) ? 5'd16 : hunt_cnt_q + 5'd1;
    // Compare against the CRC word including the bit arriving this cycle.
    assign crc_match = (crc_q == rx_shift);

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        hunt_cnt_d   = hunt_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        crc_d        = crc_q;
        payload_d    = payload_q;
        rx_crc_d     = rx_crc_q;
        idle_d       = idle_q;
        data_out_d   = data_out_q;
        crc_ok_d     = crc_ok_q;
        err_cnt_d    = err_cnt_q;
        frame_done_d = 1'b0;
        crc_err_d    = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            ST_HUNT: begin
                idle_d = '0;
                if (bit_valid) begin
                    sh_d       = sh_shift;
                    hunt_cnt_d = hunt_inc;
                    if (hunt_inc == 5'd16 && sh_shift == SYNC_WORD) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        crc_d      = CRC_INIT;
                        hunt_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_valid) begin
                    payload_d = DATA_W'({payload_q, bit_in});
                    crc_d     = crc_step;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d   = ST_CRC;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (bit_valid) begin
                    rx_crc_d = rx_shift;
                    if (bit_cnt_q == BCW'(15)) begin
                        data_out_d   = payload_q;
                        crc_ok_d     = crc_match;
                        frame_done_d = 1'b1;
                        crc_err_d    = ~crc_match;
                        if (!crc_match && err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        state_d    = ST_HUNT;
                        hunt_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_HUNT;
                hunt_cnt_d = '0;
            end
        endcase

        // Inter-bit timeout while locked; a strobe in the same cycle wins.
        if (state_q != ST_HUNT) begin
            if (bit_valid) begin
                idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
                abort_d    = 1'b1;
                state_d    = ST_HUNT;
                hunt_cnt_d = '0;
                idle_d     = '0;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= ST_HUNT;
            sh_q         <= '0;
            hunt_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            crc_q        <= CRC_INIT;
            payload_q    <= '0;
            rx_crc_q     <= '0;
            idle_q       <= '0;
            data_out_q   <= '0;
            crc_ok_q     <= 1'b0;
            frame_done_q <= 1'b0;
            crc_err_q    <= 1'b0;
            abort_q      <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            hunt_cnt_q   <= hunt_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            crc_q        <= crc_d;
            payload_q    <= payload_d;
            rx_crc_q     <= rx_crc_d;
            idle_q       <= idle_d;
            data_out_q   <= data_out_d;
            crc_ok_q     <= crc_ok_d;
            frame_done_q <= frame_done_d;
            crc_err_q    <= crc_err_d;
            abort_q      <= abort_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign crc_err    = crc_err_q;
    assign abort      = abort_q;
    assign sync_lock  = (state_q == ST_DATA) || (state_q == ST_CRC);
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_crc16_frame_rx.sv
// tb/tb_crc16_frame_rx.sv - self-checking bench for crc16_frame_rx
module tb_crc16_frame_rx;
    localparam int DW = 72;
    localparam int TO = 1024;
    localparam logic [15:0] SYNC = 16'hA55A;

    logic          clk_sys;
    logic          rst_n;
    logic          bit_in;
    logic          bit_valid;
    logic [DW-1:0] data_out;
    logic          frame_done;
    logic          crc_ok;
    logic          crc_err;
    logic          abort;
    logic          sync_lock;
    logic [7:0]    err_cnt;

    crc16_frame_rx #(
        .DATA_W    (DW),
        .SYNC_WORD (SYNC),
        .POLY      (16'h1021),
        .CRC_INIT  (16'hFFFF),
        .TIMEOUT   (TO)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .abort      (abort),
        .sync_lock  (sync_lock),
        .err_cnt    (err_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [DW-1:0] payload;
        logic [15:0]   crc_tx;
        logic          ok;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          ok;
    } exp_t;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_crc_err = 0;
    int n_abort  = 0;

    exp_t          exp_q[$];
    exp_t          e;
    int            model_err = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_ok   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [DW-1:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = DW - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Scoreboard: expected frames are queued when driven and retired on frame_done.
    always @(negedge clk_sys) begin
        if (crc_err) n_crc_err++;
        if (abort)   n_abort++;
        if (frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 128'(exp_q.size()), 128'd1);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 128'(data_out), 128'(e.data));
                check("crc_ok", 128'(crc_ok), 128'(e.ok));
                check("crc_err", 128'(crc_err), 128'(!e.ok));
                if (!e.ok && model_err != 255) model_err++;
                check("err_cnt", 128'(err_cnt), 128'(model_err));
                last_data = e.data;
                last_ok   = e.ok;
            end
        end
    end

    task automatic strobe(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk_sys);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) strobe(v[i]);
    endtask

    task automatic send_frame(input logic [DW-1:0] p, input logic [15:0] c,
                              input int gap_at, input int gap_len, input logic ok);
        exp_t x;
        x.data = p;
        x.ok   = ok;
        exp_q.push_back(x);
        send_bits(128'(SYNC), 16);
        for (int i = DW - 1; i >= 0; i--) begin
            strobe(p[i]);
            if (i == gap_at && gap_len > 0) idle_cycles(gap_len);
        end
        send_bits(128'(c), 16);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 128'(data_out), 128'd0);
        check({tag, "_frame_done"}, 128'(frame_done), 128'd0);
        check({tag, "_crc_ok"}, 128'(crc_ok), 128'd0);
        check({tag, "_crc_err"}, 128'(crc_err), 128'd0);
        check({tag, "_abort"}, 128'(abort), 128'd0);
        check({tag, "_sync_lock"}, 128'(sync_lock), 128'd0);
        check({tag, "_err_cnt"}, 128'(err_cnt), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[6];

    initial begin
        int base_done;
        int base_abort;
        int base_err;
        int waited;
        logic seen;
        logic [DW-1:0] p;

        tbl[0] = '{72'h313233343536373839, 16'h29B1, 1'b1};
        tbl[1] = '{72'h313233343536373839, 16'h29B0, 1'b0};
        tbl[2] = '{72'h0, crc_model(72'h0), 1'b1};
        tbl[3] = '{{DW{1'b1}}, crc_model({DW{1'b1}}), 1'b1};
        tbl[4] = '{72'hA55AA55AA55AA55AA5, crc_model(72'hA55AA55AA55AA55AA5), 1'b1};
        tbl[5] = '{72'hDEADBEEFCAFEF00D12, crc_model(72'hDEADBEEFCAFEF00D12) ^ 16'h8000, 1'b0};

        rst_n     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        idle_cycles(3);
        check_all_zero("reset");
        rst_n = 1'b0;
        idle_cycles(2);

        // Table-driven frames, sent back-to-back.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].payload, tbl[i].crc_tx, -1, 0, tbl[i].ok);
        end
        idle_cycles(3);
        check("table_frames", 128'(n_done), 128'd6);
        check("table_err_cnt", 128'(err_cnt), 128'd2);

        // No false lock on partial / shifted sync.
        base_done = n_done;
        send_bits(128'hFFFF, 16);
        strobe(1'b0);
        strobe(1'b1);
        check("no_lock_prefix", 128'(sync_lock), 128'd0);
        send_bits(128'(SYNC >> 1), 15);
        check("no_lock_15_sync_bits", 128'(sync_lock), 128'd0);
        strobe(SYNC[0]);
        check("lock_at_16th_bit", 128'(sync_lock), 128'd1);
        exp_q.push_back('{72'h313233343536373839, 1'b1});
        send_bits(128'h313233343536373839, DW);
        check("lock_through_payload", 128'(sync_lock), 128'd1);
        send_bits(128'h29B1, 16);
        check("unlock_after_crc", 128'(sync_lock), 128'd0);
        idle_cycles(3);
        check("hunt_one_frame", 128'(n_done - base_done), 128'd1);

        // Timeout abort after 5 payload bits.
        base_abort = n_abort;
        send_bits(128'(SYNC), 16);
        send_bits(128'h15, 5);
        check("lock_before_abort", 128'(sync_lock), 128'd1);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < TO + 10) begin
            idle_cycles(1);
            waited++;
            if (abort) seen = 1'b1;
        end
        check("abort_seen", 128'(seen), 128'd1);
        check("abort_latency", 128'(waited), 128'(TO));
        check("sync_lock_after_abort", 128'(sync_lock), 128'd0);
        check("data_out_kept", 128'(data_out), 128'(last_data));
        check("crc_ok_kept", 128'(crc_ok), 128'(last_ok));
        check("err_cnt_kept", 128'(err_cnt), 128'(model_err));
        idle_cycles(1);
        check("abort_one_cycle", 128'(abort), 128'd0);

        // A strobe landing on the timeout cycle wins.
        p = 72'h0123456789ABCDEF55;
        send_frame(p, crc_model(p), 40, TO - 1, 1'b1);
        idle_cycles(3);
        check("gap_no_abort", 128'(n_abort - base_abort), 128'd1);
        check("gap_frame_data", 128'(data_out), 128'(p));

        // Reset mid-CRC.
        send_bits(128'(SYNC), 16);
        send_bits(128'h313233343536373839, DW);
        send_bits(128'h29, 8);
        rst_n = 1'b1;
        #1;
        check_all_zero("midreset");
        idle_cycles(2);
        rst_n     = 1'b0;
        model_err = 0;
        last_data = '0;
        last_ok   = 1'b0;
        idle_cycles(1);
        send_frame(72'h313233343536373839, 16'h29B1, -1, 0, 1'b1);
        idle_cycles(3);
        check("post_reset_ok", 128'(crc_ok), 128'd1);

        // 256 bad frames back-to-back: err_cnt saturates.
        base_err = n_crc_err;
        for (int i = 0; i < 256; i++) begin
            p = DW'(i) * 72'h0000010203040506;
            send_frame(p, crc_model(p) ^ 16'h0001, -1, 0, 1'b0);
        end
        idle_cycles(5);
        check("err_cnt_saturated", 128'(err_cnt), 128'd255);
        check("crc_err_pulses", 128'(n_crc_err - base_err), 128'd256);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
